// File: rtl/tdm_pkg.sv
// tdm_pkg: shared widths, channel data type and receiver state type for the TDM demux receiver
package tdm_pkg;
  localparam int WIDTH = 4;
  localparam int NCH = 8;
  localparam int ID_W = $clog2(NCH);
  localparam int ERRW = 8;
  typedef logic [WIDTH-1:0] chan_t;
  typedef enum logic {COLLECT, RESYNC} rx_state_t;
endpackage

// File: rtl/tdm_lane_bank.sv
// tdm_lane_bank: per-channel shadow registers plus committed outputs updated atomically on commit
//   clk, rst      clock, async active-high reset
//   wr_en/wr_idx/wr_data  beat write into shadow[wr_idx]
//   commit        copy shadow (including this cycle's write) to d
//   d             committed channel values
module tdm_lane_bank
  import tdm_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ID_W-1:0]   wr_idx,
  input  chan_t             wr_data,
  input  logic              commit,
  output chan_t [NCH-1:0]   d
);
  chan_t [NCH-1:0] shadow, shadow_nxt;
  // the committing beat's own lane is taken from the bus, not the stale shadow
  always_comb begin
    shadow_nxt = shadow;
    if (wr_en) shadow_nxt[wr_idx] = wr_data;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      shadow <= '0;
      d <= '0;
    end else begin
      shadow <= shadow_nxt;
      if (commit) d <= shadow_nxt;
    end
endmodule

// File: rtl/tdm_demux_receiver.sv
// tdm_demux_receiver: collects (ENTRADA, ID) beats per channel and publishes an 8-channel snapshot at frame end
//   CLK, RST (async, active-high); ENTRADA/ID/VALID beat input; CLR_ERR clears SEQ_ERR
//   D0..D7 committed channels; FRAME_OK commit pulse; SEQ_ERR sticky error; ERR_CNT saturating error count
//   TDM_SEQ_CHECK_EN: enables in-order ID checking with resync; otherwise any order, ID 7 commits
module tdm_demux_receiver
  import tdm_pkg::*;
(
  input  logic              CLK,
  input  logic              RST,
  input  logic [WIDTH-1:0]  ENTRADA,
  input  logic [ID_W-1:0]   ID,
  input  logic              VALID,
  input  logic              CLR_ERR,
  output logic [WIDTH-1:0]  D0,
  output logic [WIDTH-1:0]  D1,
  output logic [WIDTH-1:0]  D2,
  output logic [WIDTH-1:0]  D3,
  output logic [WIDTH-1:0]  D4,
  output logic [WIDTH-1:0]  D5,
  output logic [WIDTH-1:0]  D6,
  output logic [WIDTH-1:0]  D7,
  output logic              FRAME_OK,
  output logic              SEQ_ERR,
  output logic [ERRW-1:0]   ERR_CNT
);
  logic wr_en, commit;
  chan_t [NCH-1:0] d;
`ifdef TDM_SEQ_CHECK_EN
  rx_state_t state;
  logic [ID_W-1:0] exp_id;
  logic in_seq, err;
  // ID 0 always restarts a frame, whether in sequence, out of sequence or resyncing
  always_comb begin
    in_seq = state == COLLECT && ID == exp_id;
    wr_en = VALID && (in_seq || ID == '0);
    commit = VALID && in_seq && exp_id == ID_W'(NCH - 1);
    err = VALID && state == COLLECT && ID != exp_id;
  end
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      state <= COLLECT;
      exp_id <= '0;
      SEQ_ERR <= 1'b0;
      ERR_CNT <= '0;
    end else begin
      if (wr_en) begin
        exp_id <= ID + ID_W'(1);
        state <= COLLECT;
      end else if (err) state <= RESYNC;
      if (err || CLR_ERR) SEQ_ERR <= err;
      if (err && ERR_CNT != '1) ERR_CNT <= ERR_CNT + ERRW'(1);
    end
`else
  logic unused;
  assign unused = CLR_ERR;
  assign wr_en = VALID;
  assign commit = VALID && ID == ID_W'(NCH - 1);
  assign SEQ_ERR = 1'b0;
  assign ERR_CNT = '0;
`endif
  always_ff @(posedge CLK or posedge RST)
    if (RST) FRAME_OK <= 1'b0;
    else FRAME_OK <= commit;
  tdm_lane_bank u_bank (
    .clk(CLK),
    .rst(RST),
    .wr_en(wr_en),
    .wr_idx(ID),
    .wr_data(ENTRADA),
    .commit(commit),
    .d(d)
  );
  assign {D7, D6, D5, D4, D3, D2, D1, D0} = d;
endmodule
